// File: rtl/mem_request_master.sv
// Initiator for the memory unit func/execute/is_ready protocol: runs one client
// operation at a time, grants garbage collection and retries refused allocations.
module mem_request_master #(
  parameter int         ADDR_WIDTH        = 10,
  parameter int         DATA_WIDTH        = 64,
  parameter int         TIMEOUT           = 1023,
  parameter int         MAX_RETRY         = 3,
  parameter logic [1:0] FUNC_GET_CONTENTS = 2'd0,
  parameter logic [1:0] FUNC_SET_CONTENTS = 2'd1,
  parameter logic [1:0] FUNC_GET_FREE     = 2'd2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_req_op,
  input  logic [ADDR_WIDTH-1:0] i_req_addr1,
  input  logic [ADDR_WIDTH-1:0] i_req_addr2,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  output logic                  o_resp_valid,
  output logic                  o_resp_err,
  output logic [DATA_WIDTH-1:0] o_resp_data1,
  output logic [DATA_WIDTH-1:0] o_resp_data2,
  output logic [ADDR_WIDTH-1:0] o_resp_addr,
  output logic [1:0]            o_mem_func,
  output logic                  o_mem_execute,
  output logic [ADDR_WIDTH-1:0] o_mem_address1,
  output logic [ADDR_WIDTH-1:0] o_mem_address2,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic                  i_mem_is_ready,
  input  logic [ADDR_WIDTH-1:0] i_mem_free_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data1,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data2,
  input  logic                  i_mem_gc,
  output logic                  o_gc_ready
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ALLOC = 2'd2;
  localparam logic [1:0] OP_CONS  = 2'd3;

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GC_GRANT, S_RESP} state_t;

  state_t                r_state, w_state_next;
  logic                  r_live;
  logic [1:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr1, r_addr2, r_alloc_addr, r_resp_addr;
  logic [DATA_WIDTH-1:0] r_data, r_resp_data1, r_resp_data2;
  logic                  r_cons_wr, r_first, r_resp_err;
  logic [TW-1:0]         r_tmo_cnt;
  logic [RW-1:0]         r_retry_cnt;

  logic                  w_accept, w_done, w_is_alloc, w_refused, w_tmo_hit, w_exhausted;
  logic [TW-1:0]         w_tmo_inc;

  assign w_accept    = o_req_ready && i_req_valid;
  assign w_done      = (r_state == S_WAIT) && !r_first && i_mem_is_ready;
  assign w_is_alloc  = (r_op == OP_ALLOC) || ((r_op == OP_CONS) && !r_cons_wr);
  assign w_refused   = w_done && w_is_alloc && i_mem_gc;
  assign w_tmo_inc   = (r_tmo_cnt >= TMO_LIM) ? r_tmo_cnt : r_tmo_cnt + TW'(1);
  assign w_tmo_hit   = (w_tmo_inc >= TMO_LIM);
  assign w_exhausted = (r_retry_cnt >= RETRY_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_done) begin
          if (w_refused)                         w_state_next = S_GC_GRANT;
          else if ((r_op == OP_CONS) && !r_cons_wr) w_state_next = S_ISSUE;
          else                                   w_state_next = S_RESP;
        end else if (w_tmo_hit) begin
          w_state_next = S_RESP;
        end
      end
      S_GC_GRANT: begin
        if (!i_mem_gc)      w_state_next = w_exhausted ? S_RESP : S_ISSUE;
        else if (w_tmo_hit) w_state_next = S_RESP;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live       <= 1'b0;
      r_op         <= '0;
      r_addr1      <= '0;
      r_addr2      <= '0;
      r_data       <= '0;
      r_alloc_addr <= '0;
      r_cons_wr    <= 1'b0;
      r_first      <= 1'b0;
      r_tmo_cnt    <= '0;
      r_retry_cnt  <= '0;
      r_resp_err   <= 1'b0;
      r_resp_data1 <= '0;
      r_resp_data2 <= '0;
      r_resp_addr  <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_op        <= i_req_op;
        r_addr1     <= i_req_addr1;
        r_addr2     <= i_req_addr2;
        r_data      <= i_req_data;
        r_cons_wr   <= 1'b0;
        r_retry_cnt <= '0;
      end
      case (r_state)
        S_ISSUE: begin
          r_tmo_cnt <= '0;
          r_first   <= 1'b1;
        end
        S_WAIT: begin
          r_first   <= 1'b0;
          r_tmo_cnt <= w_tmo_inc;
          if (w_refused) begin
            r_tmo_cnt <= '0;
          end else if (w_done) begin
            r_resp_err <= 1'b0;
            case (r_op)
              OP_READ: begin
                r_resp_data1 <= i_mem_read_data1;
                r_resp_data2 <= i_mem_read_data2;
              end
              OP_ALLOC: r_resp_addr <= i_mem_free_addr;
              OP_CONS: begin
                if (!r_cons_wr) begin
                  r_alloc_addr <= i_mem_free_addr;
                  r_cons_wr    <= 1'b1;
                end else begin
                  r_resp_addr <= r_alloc_addr;
                end
              end
              default: ;
            endcase
          end else if (w_tmo_hit) begin
            r_resp_err <= 1'b1;
          end
        end
        S_GC_GRANT: begin
          r_tmo_cnt <= w_tmo_inc;
          if (!i_mem_gc) begin
            if (w_exhausted) r_resp_err  <= 1'b1;
            else             r_retry_cnt <= r_retry_cnt + RW'(1);
          end else if (w_tmo_hit) begin
            r_resp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A CONS runs GET_FREE(1) first, then SET_CONTENTS at the address it returned.
  always_comb begin
    o_mem_execute    = 1'b0;
    o_mem_func       = '0;
    o_mem_address1   = '0;
    o_mem_address2   = '0;
    o_mem_write_data = '0;
    if (r_state == S_ISSUE) begin
      o_mem_execute = 1'b1;
      case (r_op)
        OP_READ: begin
          o_mem_func     = FUNC_GET_CONTENTS;
          o_mem_address1 = r_addr1;
          o_mem_address2 = r_addr2;
        end
        OP_WRITE: begin
          o_mem_func       = FUNC_SET_CONTENTS;
          o_mem_address1   = r_addr1;
          o_mem_write_data = r_data;
        end
        OP_ALLOC: begin
          o_mem_func       = FUNC_GET_FREE;
          o_mem_write_data = r_data;
        end
        default: begin
          if (r_cons_wr) begin
            o_mem_func       = FUNC_SET_CONTENTS;
            o_mem_address1   = r_alloc_addr;
            o_mem_write_data = r_data;
          end else begin
            o_mem_func       = FUNC_GET_FREE;
            o_mem_write_data = DATA_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign o_req_ready  = r_live && (r_state == S_IDLE) && i_mem_is_ready && !i_mem_gc;
  assign o_gc_ready   = r_live && i_mem_gc && ((r_state == S_IDLE) || (r_state == S_GC_GRANT));
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_err   = (r_state == S_RESP) && r_resp_err;
  assign o_resp_data1 = r_resp_data1;
  assign o_resp_data2 = r_resp_data2;
  assign o_resp_addr  = r_resp_addr;

endmodule

// File: tb/tb_mem_request_master.sv
// Directed bench for mem_request_master with a behavioural memory unit and a
// response scoreboard.
module tb_mem_request_master;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ALLOC = 2'd2;
  localparam logic [1:0] OP_CONS  = 2'd3;
  localparam logic [1:0] F_GET    = 2'd0;
  localparam logic [1:0] F_SET    = 2'd1;
  localparam logic [1:0] F_FREE   = 2'd2;
  localparam int         LAT      = 3;
  localparam int         GCLEN    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [9:0]  req_addr1, req_addr2;
  logic [63:0] req_data;
  logic        resp_valid, resp_err;
  logic [63:0] resp_data1, resp_data2;
  logic [9:0]  resp_addr;
  logic [1:0]  mem_func;
  logic        mem_execute;
  logic [9:0]  mem_address1, mem_address2;
  logic [63:0] mem_write_data;
  logic        mem_is_ready = 1'b1;
  logic [9:0]  mem_free_addr = '0;
  logic [63:0] mem_read_data1 = '0, mem_read_data2 = '0;
  logic        mem_gc = 1'b0;
  logic        gc_ready;

  always #5 clk = ~clk;

  mem_request_master #(
    .ADDR_WIDTH(10), .DATA_WIDTH(64), .TIMEOUT(15), .MAX_RETRY(3),
    .FUNC_GET_CONTENTS(F_GET), .FUNC_SET_CONTENTS(F_SET), .FUNC_GET_FREE(F_FREE)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_addr1(req_addr1), .i_req_addr2(req_addr2), .i_req_data(req_data),
    .o_resp_valid(resp_valid), .o_resp_err(resp_err),
    .o_resp_data1(resp_data1), .o_resp_data2(resp_data2), .o_resp_addr(resp_addr),
    .o_mem_func(mem_func), .o_mem_execute(mem_execute),
    .o_mem_address1(mem_address1), .o_mem_address2(mem_address2),
    .o_mem_write_data(mem_write_data),
    .i_mem_is_ready(mem_is_ready), .i_mem_free_addr(mem_free_addr),
    .i_mem_read_data1(mem_read_data1), .i_mem_read_data2(mem_read_data2),
    .i_mem_gc(mem_gc), .o_gc_ready(gc_ready)
  );

  // Behavioural memory unit; configuration knobs are written only by the stimulus.
  logic        cfg_stuck = 1'b0;
  int          cfg_refuse_at = 0, cfg_refuse_num = 0;
  logic [9:0]  cfg_gc_free = '0;

  logic [63:0] m_mem [0:1023];
  int          m_busy = 0, m_exec_cnt = 0, m_getfree_cnt = 0, m_gc_cycles = 0, m_gc_left = 0;
  logic [1:0]  m_func = '0;
  logic [9:0]  m_a1 = '0, m_a2 = '0, m_free_ptr = '0;
  logic [63:0] m_wd = '0;

  always @(posedge clk) begin
    if (rst) begin
      mem_is_ready <= 1'b1;
      mem_gc       <= 1'b0;
      m_busy       <= 0;
      m_gc_left    <= 0;
      m_free_ptr   <= 10'd100;
    end else begin
      if (mem_execute) begin
        m_exec_cnt   <= m_exec_cnt + 1;
        m_func       <= mem_func;
        m_a1         <= mem_address1;
        m_a2         <= mem_address2;
        m_wd         <= mem_write_data;
        mem_is_ready <= 1'b0;
        m_busy       <= LAT;
      end else if (m_busy > 1) begin
        m_busy <= m_busy - 1;
      end else if (m_busy == 1 && !cfg_stuck) begin
        m_busy       <= 0;
        mem_is_ready <= 1'b1;
        case (m_func)
          F_GET: begin
            mem_read_data1 <= m_mem[m_a1];
            mem_read_data2 <= m_mem[m_a2];
          end
          F_SET: m_mem[m_a1] <= m_wd;
          default: begin
            m_getfree_cnt <= m_getfree_cnt + 1;
            if (m_getfree_cnt >= cfg_refuse_at && m_getfree_cnt < cfg_refuse_at + cfg_refuse_num) begin
              mem_gc    <= 1'b1;
              m_gc_left <= GCLEN;
            end else begin
              mem_free_addr <= m_free_ptr;
              m_free_ptr    <= m_free_ptr + m_wd[9:0];
            end
          end
        endcase
      end
      if (mem_gc && gc_ready) begin
        m_gc_cycles <= m_gc_cycles + 1;
        m_gc_left   <= m_gc_left - 1;
        if (m_gc_left == 1) begin
          mem_gc     <= 1'b0;
          m_free_ptr <= cfg_gc_free;
        end
      end
    end
  end

  typedef struct {
    logic        err;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [9:0]  addr;
    logic        chk_d;
    logic        chk_a;
    int          exec;
    logic [1:0]  func;
  } exp_t;

  exp_t sb[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vectors++;
    assert (obs === expv) else begin
      n_miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [9:0] a1,
                        input logic [9:0] a2, input logic [63:0] d, input logic e_err,
                        input logic [63:0] e_d1, input logic [63:0] e_d2, input logic [9:0] e_addr,
                        input logic chk_d, input logic chk_a, input int e_exec,
                        input logic [1:0] e_func, output int lat);
    exp_t e;
    int   n;
    int   ex0;
    e.err = e_err; e.d1 = e_d1; e.d2 = e_d2; e.addr = e_addr;
    e.chk_d = chk_d; e.chk_a = chk_a; e.exec = e_exec; e.func = e_func;
    sb.push_back(e);
    ex0 = m_exec_cnt;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    check({name, " req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_addr1 = a1; req_addr2 = a2; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check({name, " resp_valid"}, 64'(resp_valid), 64'd1);
    e = sb.pop_front();
    check({name, " resp_err"}, 64'(resp_err), 64'(e.err));
    if (e.chk_d) begin
      check({name, " resp_data1"}, resp_data1, e.d1);
      check({name, " resp_data2"}, resp_data2, e.d2);
    end
    if (e.chk_a) check({name, " resp_addr"}, 64'(resp_addr), 64'(e.addr));
    check({name, " exec pulses"}, 64'(m_exec_cnt - ex0), 64'(e.exec));
    check({name, " last func"}, 64'(m_func), 64'(e.func));
    $display("%-12s op=%0d a1=%0d a2=%0d data=%0h -> err=%0b d1=%0h d2=%0h addr=%0d lat=%0d",
             name, op, a1, a2, d, resp_err, resp_data1, resp_data2, resp_addr, lat);
    @(posedge clk); #1;
    check({name, " resp one cycle"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int gc0;
    int hits;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr1 = '0; req_addr2 = '0; req_data = '0;

    repeat (3) @(posedge clk); #1;
    check("reset outputs", 64'({req_ready, resp_valid, resp_err, mem_execute, gc_ready}), 64'd0);
    check("reset resp_data1", resp_data1, 64'd0);
    rst = 1'b0; #1;
    check("req_ready before first edge", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("req_ready after first edge", 64'(req_ready), 64'd1);

    run_op("WRITE5",  OP_WRITE, 10'd5,  10'd0, 64'hAA,   1'b0, 64'h0, 64'h0, 10'd0, 1'b0, 1'b0, 1, F_SET, lat);
    run_op("WRITE6",  OP_WRITE, 10'd6,  10'd0, 64'hBB,   1'b0, 64'h0, 64'h0, 10'd0, 1'b0, 1'b0, 1, F_SET, lat);
    run_op("READ5_6", OP_READ,  10'd5,  10'd6, 64'h0,    1'b0, 64'hAA, 64'hBB, 10'd0, 1'b1, 1'b0, 1, F_GET, lat);
    run_op("WRITE12", OP_WRITE, 10'd12, 10'd0, 64'h1234, 1'b0, 64'h0, 64'h0, 10'd0, 1'b0, 1'b0, 1, F_SET, lat);
    run_op("READ12",  OP_READ,  10'd12, 10'd5, 64'h0,    1'b0, 64'h1234, 64'hAA, 10'd0, 1'b1, 1'b0, 1, F_GET, lat);

    run_op("CONS77",  OP_CONS,  10'd0, 10'd0, 64'h77, 1'b0, 64'h0, 64'h0, 10'd100, 1'b0, 1'b1, 2, F_SET, lat);
    run_op("CONS88",  OP_CONS,  10'd0, 10'd0, 64'h88, 1'b0, 64'h0, 64'h0, 10'd101, 1'b0, 1'b1, 2, F_SET, lat);
    run_op("READ100", OP_READ,  10'd100, 10'd101, 64'h0, 1'b0, 64'h77, 64'h88, 10'd101, 1'b1, 1'b1, 1, F_GET, lat);
    run_op("ALLOC5",  OP_ALLOC, 10'd0, 10'd0, 64'd5,  1'b0, 64'h0, 64'h0, 10'd102, 1'b0, 1'b1, 1, F_FREE, lat);

    // One refusal: gc_ready held for the whole GC, then an automatic retry.
    cfg_refuse_at = m_getfree_cnt; cfg_refuse_num = 1; cfg_gc_free = 10'd200;
    gc0 = m_gc_cycles;
    run_op("ALLOC_GC",  OP_ALLOC, 10'd0, 10'd0, 64'd3, 1'b0, 64'h0, 64'h0, 10'd200, 1'b0, 1'b1, 2, F_FREE, lat);
    check("ALLOC_GC gc_ready cycles", 64'(m_gc_cycles - gc0), 64'(GCLEN));

    // Every attempt refused: initial try plus three retries, then an error.
    cfg_refuse_at = m_getfree_cnt; cfg_refuse_num = 4; cfg_gc_free = 10'd300;
    gc0 = m_gc_cycles;
    run_op("ALLOC_EXH", OP_ALLOC, 10'd0, 10'd0, 64'd3, 1'b1, 64'h0, 64'h0, 10'd0, 1'b0, 1'b0, 4, F_FREE, lat);
    check("ALLOC_EXH gc_ready cycles", 64'(m_gc_cycles - gc0), 64'(4 * GCLEN));

    cfg_refuse_at = m_getfree_cnt; cfg_refuse_num = 1; cfg_gc_free = 10'd400;
    run_op("CONS_GC", OP_CONS, 10'd0, 10'd0, 64'h99, 1'b0, 64'h0, 64'h0, 10'd400, 1'b0, 1'b1, 3, F_SET, lat);
    cfg_refuse_num = 0;
    run_op("READ400", OP_READ, 10'd400, 10'd100, 64'h0, 1'b0, 64'h99, 64'h77, 10'd400, 1'b1, 1'b1, 1, F_GET, lat);

    // Memory never completes: error after exactly TIMEOUT wait cycles.
    cfg_stuck = 1'b1;
    run_op("READ_TMO", OP_READ, 10'd12, 10'd12, 64'h0, 1'b1, 64'h0, 64'h0, 10'd0, 1'b0, 1'b0, 1, F_GET, lat);
    check("READ_TMO latency", 64'(lat), 64'd16);
    check("READ_TMO req_ready while stuck", 64'(req_ready), 64'd0);
    cfg_stuck = 1'b0;
    @(posedge clk); #1;
    check("READ_TMO req_ready after recovery", 64'(req_ready), 64'd1);

    // Reset in the middle of a WAIT: nothing may come out.
    req_valid = 1'b1; req_op = OP_READ; req_addr1 = 10'd12; req_addr2 = 10'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; #1;
    check("mid-reset outputs", 64'({req_ready, resp_valid, resp_err, mem_execute, gc_ready, mem_func}), 64'd0);
    check("mid-reset resp_addr", 64'(resp_addr), 64'd0);
    check("mid-reset resp_data1", resp_data1, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid) hits++;
    end
    check("no response after reset", 64'(hits), 64'd0);
    $display("RESET_WAIT   reset asserted during WAIT, stray responses=%0d", hits);
    run_op("READ_POST", OP_READ, 10'd12, 10'd5, 64'h0, 1'b0, 64'h1234, 64'hAA, 10'd0, 1'b1, 1'b0, 1, F_GET, lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
